// File: rtl/pipe_reg.sv
// DEPTH-stage, WIDTH-bit valid/ready register pipeline. Stages hold on stall,
// empty stages collapse, flush drops all words, count tracks occupancy.
module pipe_reg #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] vld_q, vld_d, rdy;
  logic [WIDTH-1:0] dat_q  [DEPTH];
  logic [WIDTH-1:0] dat_d  [DEPTH];
  logic             up_vld [DEPTH];
  logic [WIDTH-1:0] up_dat [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  // A stage may load when any stage at or after it can make room.
  always_comb begin
    logic chain;
    chain        = out_ready | ~vld_q[DEPTH-1];
    rdy          = '0;
    rdy[DEPTH-1] = chain;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      chain  = chain | ~vld_q[i];
      rdy[i] = chain;
    end
  end

  assign in_ready = rdy[0] & rst_n & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_up
      if (gi == 0) begin : g_head
        assign up_vld[gi] = in_valid;
        assign up_dat[gi] = in_data;
      end else begin : g_link
        assign up_vld[gi] = vld_q[gi-1];
        assign up_dat[gi] = dat_q[gi-1];
      end
    end
  endgenerate

  // Data only moves with a valid word, so bubbles leave the data registers quiet.
  always_comb begin
    vld_d   = vld_q;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dat_d[i] = dat_q[i];
      if (flush) begin
        vld_d[i] = 1'b0;
      end else if (rdy[i]) begin
        vld_d[i] = up_vld[i];
        if (up_vld[i]) begin
          dat_d[i] = up_dat[i];
        end
      end
      count_d = count_d + CW'(vld_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];
  assign count     = count_q;

endmodule
